// File: rtl/ifft_frame_sched.sv
// ifft_frame_sched: shares one 128-point IFFT between two sample producers, one whole frame at a time,
// with round-robin grants, an in-flight frame credit limit and source tagging of output frames.
module ifft_frame_sched #(
  parameter int IFFT_STAGE   = 7,
  parameter int DWIDTH       = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                  iclk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DWIDTH-1:0]     req0_re,
  input  logic [DWIDTH-1:0]     req0_im,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DWIDTH-1:0]     req1_re,
  input  logic [DWIDTH-1:0]     req1_im,
  output logic                  req1_ready,
  output logic [DWIDTH-1:0]     pf_re,
  output logic [DWIDTH-1:0]     pf_im,
  output logic [IFFT_STAGE-1:0] pf_index,
  output logic                  pf_en,
  input  logic                  ifft_oen,
  output logic                  oframe_src,
  output logic                  oframe_done,
  output logic [1:0]            inflight,
  output logic                  busy,
  output logic                  err
);

  localparam logic [0:0]            ST_IDLE    = 1'b0;
  localparam logic [0:0]            ST_LOAD    = 1'b1;
  localparam logic [IFFT_STAGE-1:0] CNT_LAST   = {IFFT_STAGE{1'b1}};
  localparam logic [IFFT_STAGE-1:0] CNT_ONE    = {{(IFFT_STAGE-1){1'b0}}, 1'b1};
  localparam logic [1:0]            MAX_CREDIT = 2'(MAX_INFLIGHT);

  logic [0:0]              state_q, state_d;
  logic                    grant_q, grant_d;
  logic [IFFT_STAGE-1:0]   ld_cnt_q, ld_cnt_d;
  logic [IFFT_STAGE-1:0]   out_cnt_q, out_cnt_d;
  logic [1:0]              inflight_q, inflight_d;
  logic [MAX_INFLIGHT-1:0] fifo_q, fifo_d;
  logic [DWIDTH-1:0]       pf_re_q, pf_re_d, pf_im_q, pf_im_d;
  logic [IFFT_STAGE-1:0]   pf_index_q, pf_index_d;
  logic                    pf_en_q, pf_en_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic       arb_pick;
  logic       accept;
  logic       push;
  logic       pop;
  logic       oen_ok;
  logic [1:0] wr_idx;

  // grant_q doubles as the last-grant memory: it holds the winner until the next grant
  assign arb_pick   = (req0_valid && req1_valid) ? ~grant_q : req1_valid;
  assign req0_ready = (state_q == ST_LOAD) && !grant_q;
  assign req1_ready = (state_q == ST_LOAD) && grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ld_cnt_d = ld_cnt_q;
    accept   = 1'b0;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((inflight_q < MAX_CREDIT) && (req0_valid || req1_valid)) begin
          grant_d = arb_pick;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        accept = grant_q ? req1_valid : req0_valid;
        if (accept) begin
          if (ld_cnt_q == CNT_LAST) begin
            ld_cnt_d = '0;
            state_d  = ST_IDLE;
            push     = 1'b1;
          end else begin
            ld_cnt_d = ld_cnt_q + CNT_ONE;
          end
        end else begin
          ld_cnt_d = ld_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pf_en_d = accept;
    if (accept) begin
      pf_index_d = ld_cnt_q;
      pf_re_d    = grant_q ? req1_re : req0_re;
      pf_im_d    = grant_q ? req1_im : req0_im;
    end else begin
      pf_index_d = pf_index_q;
      pf_re_d    = pf_re_q;
      pf_im_d    = pf_im_q;
    end
  end

  // Output beats only count while a frame is actually in flight; stray beats flag err
  always_comb begin
    oen_ok = ifft_oen && (inflight_q != 2'd0);
    pop    = oen_ok && (out_cnt_q == CNT_LAST);
    done_d = pop;
    err_d  = err_q || (ifft_oen && (inflight_q == 2'd0));
    if (oen_ok) begin
      out_cnt_d = pop ? '0 : (out_cnt_q + CNT_ONE);
    end else begin
      out_cnt_d = out_cnt_q;
    end
    case ({push, pop})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Source FIFO is a shift register whose occupancy always equals inflight_q; head is bit 0
  always_comb begin
    if (pop) begin
      fifo_d = fifo_q >> 1;
      wr_idx = inflight_q - 2'd1;
    end else begin
      fifo_d = fifo_q;
      wr_idx = inflight_q;
    end
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (push && (2'(i) == wr_idx)) begin
        fifo_d[i] = grant_q;
      end else begin
        fifo_d[i] = fifo_d[i];
      end
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b1;
      ld_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 2'd0;
      fifo_q     <= '0;
      pf_re_q    <= '0;
      pf_im_q    <= '0;
      pf_index_q <= '0;
      pf_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ld_cnt_q   <= ld_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      pf_re_q    <= pf_re_d;
      pf_im_q    <= pf_im_d;
      pf_index_q <= pf_index_d;
      pf_en_q    <= pf_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign pf_re       = pf_re_q;
  assign pf_im       = pf_im_q;
  assign pf_index    = pf_index_q;
  assign pf_en       = pf_en_q;
  assign oframe_src  = (inflight_q != 2'd0) && fifo_q[0];
  assign oframe_done = done_q;
  assign inflight    = inflight_q;
  assign busy        = (state_q == ST_LOAD) || (inflight_q != 2'd0);
  assign err         = err_q;

endmodule

// File: tb/tb_ifft_frame_sched.sv
// Directed bench for ifft_frame_sched: arbitration vector table plus hand-written
// contention, credit-limit, stall/coincidence, error and mid-frame reset sequences.
module tb_ifft_frame_sched;
  logic        iclk = 1'b0;
  logic        rst  = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_re = 16'd0, req0_im = 16'd0, req1_re = 16'd0, req1_im = 16'd0;
  logic        req0_ready, req1_ready;
  logic [15:0] pf_re, pf_im;
  logic [6:0]  pf_index;
  logic        pf_en;
  logic        ifft_oen = 1'b0;
  logic        oframe_src, oframe_done;
  logic [1:0]  inflight;
  logic        busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit v0;
    bit v1;
    bit exp_who;
  } arb_vec_t;
  arb_vec_t vecs[8];

  ifft_frame_sched #(.IFFT_STAGE(7), .DWIDTH(16), .MAX_INFLIGHT(2)) dut (
    .iclk(iclk), .rst(rst),
    .req0_valid(req0_valid), .req0_re(req0_re), .req0_im(req0_im), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_re(req1_re), .req1_im(req1_im), .req1_ready(req1_ready),
    .pf_re(pf_re), .pf_im(pf_im), .pf_index(pf_index), .pf_en(pf_en),
    .ifft_oen(ifft_oen), .oframe_src(oframe_src), .oframe_done(oframe_done),
    .inflight(inflight), .busy(busy), .err(err)
  );

  always #5 iclk = ~iclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_pf_en"}, pf_en, 1'b0);
    chk({tag, "_pf_index"}, 32'(pf_index), 32'd0);
    chk({tag, "_pf_re"}, 32'(pf_re), 32'd0);
    chk({tag, "_pf_im"}, 32'(pf_im), 32'd0);
    chk1({tag, "_ready0"}, req0_ready, 1'b0);
    chk1({tag, "_ready1"}, req1_ready, 1'b0);
    chk1({tag, "_src"}, oframe_src, 1'b0);
    chk1({tag, "_done"}, oframe_done, 1'b0);
    chk({tag, "_inflight"}, 32'(inflight), 32'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // Streams one 128-beat frame from requester 'who' (re = index, im = ~index) and checks pf_* each cycle.
  task automatic stream(input bit who, input bit gappy, input bit follow, input bit hold);
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    int pidx = 0;
    bit pacc = 1'b0;
    bit v;
    bit rdy;
    while (idx < 128 && cyc < 1000) begin
      @(negedge iclk);
      if (pf_en !== pacc) bad++;
      else if (pacc && (pf_index !== 7'(pidx) || pf_re !== 16'(pidx) || pf_im !== ~16'(pidx))) bad++;
      if (who ? req0_ready : req1_ready) bad++;
      v   = gappy ? ~cyc[0] : 1'b1;
      rdy = who ? req1_ready : req0_ready;
      if (who) begin
        req1_valid = v; req1_re = 16'(idx); req1_im = ~16'(idx);
      end else begin
        req0_valid = v; req0_re = 16'(idx); req0_im = ~16'(idx);
      end
      pacc = v && rdy;
      pidx = idx;
      if (follow) ifft_oen = pacc;
      if (pacc) idx++;
      cyc++;
    end
    @(negedge iclk);
    if (idx == 128 && (pf_en !== 1'b1 || pf_index !== 7'd127 || pf_re !== 16'd127 || pf_im !== ~16'd127)) bad++;
    if (follow) ifft_oen = 1'b0;
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    chk("stream_beats", 32'(idx), 32'd128);
    chk("stream_pf_ready", 32'(bad), 32'd0);
  endtask

  // Drives 128 consecutive output beats and checks the source tag and the single done pulse.
  task automatic drain(input bit exp_src);
    int bad = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge iclk);
      if (oframe_src !== exp_src || oframe_done !== 1'b0) bad++;
      ifft_oen = 1'b1;
    end
    @(negedge iclk);
    ifft_oen = 1'b0;
    chk("drain_src_done_low", 32'(bad), 32'd0);
    chk1("drain_done_pulse", oframe_done, 1'b1);
  endtask

  initial begin
    int acc;
    int bad;
    vecs[0] = '{1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge iclk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge iclk);
    chk_quiet("post_reset");

    // Contention: both valid throughout, each frame drained while the next loads
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    stream(1'b0, 1'b0, 1'b0, 1'b1);
    fork stream(1'b1, 1'b0, 1'b0, 1'b1); drain(1'b0); join
    fork stream(1'b0, 1'b0, 1'b0, 1'b1); drain(1'b1); join
    fork stream(1'b1, 1'b0, 1'b0, 1'b0); drain(1'b0); join
    drain(1'b1);
    chk("contention_inflight", 32'(inflight), 32'd0);

    // Arbitration table: one frame per record, fully drained before the next
    for (int k = 0; k < 8; k++) begin
      @(negedge iclk);
      req0_valid = vecs[k].v0;
      req1_valid = vecs[k].v1;
      @(posedge iclk);
      #1;
      chk1("arb_ready0", req0_ready, vecs[k].exp_who == 1'b0);
      chk1("arb_ready1", req1_ready, vecs[k].exp_who == 1'b1);
      stream(vecs[k].exp_who, 1'b0, 1'b0, 1'b0);
      chk("load_inflight", 32'(inflight), 32'd1);
      chk1("load_busy", busy, 1'b1);
      drain(vecs[k].exp_who);
      chk("drain_inflight", 32'(inflight), 32'd0);
      @(negedge iclk);
      chk1("done_single", oframe_done, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end

    // Credit limit: two frames loaded, no output, both readys must stay low
    stream(1'b0, 1'b0, 1'b0, 1'b0);
    stream(1'b1, 1'b0, 1'b0, 1'b0);
    chk("credit_inflight2", 32'(inflight), 32'd2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iclk);
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("credit_blocked", 32'(bad), 32'd0);
    drain(1'b0);
    chk("credit_inflight1", 32'(inflight), 32'd1);
    chk1("credit_no_grant_yet", req0_ready, 1'b0);
    @(posedge iclk);
    #1;
    chk1("credit_grant0", req0_ready, 1'b1);
    chk1("credit_grant1", req1_ready, 1'b0);
    stream(1'b0, 1'b0, 1'b0, 1'b0);
    drain(1'b1);
    drain(1'b0);
    chk("credit_empty", 32'(inflight), 32'd0);

    // Stalled load from req1 whose last accept coincides with the last output beat of req0's frame
    stream(1'b0, 1'b0, 1'b0, 1'b0);
    stream(1'b1, 1'b1, 1'b1, 1'b0);
    chk("coincide_inflight", 32'(inflight), 32'd1);
    chk1("coincide_done", oframe_done, 1'b1);
    chk1("coincide_src", oframe_src, 1'b1);
    drain(1'b1);
    chk("coincide_empty", 32'(inflight), 32'd0);

    // Stray output beat with nothing in flight
    @(negedge iclk);
    ifft_oen = 1'b1;
    @(negedge iclk);
    ifft_oen = 1'b0;
    chk1("err_set", err, 1'b1);
    chk("err_inflight", 32'(inflight), 32'd0);
    chk1("err_no_done", oframe_done, 1'b0);
    stream(1'b0, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    chk1("err_sticky", err, 1'b1);

    // Reset in the middle of a frame from req0 (last grant = 0, so a tie would otherwise go to 1)
    acc = 0;
    for (int i = 0; i < 300 && acc < 60; i++) begin
      @(negedge iclk);
      req0_valid = 1'b1;
      req0_re = 16'(acc + 1);
      req0_im = ~16'(acc + 1);
      if (req0_ready) acc++;
    end
    chk("reset_partial_beats", 32'(acc), 32'd60);
    @(negedge iclk);
    chk1("pre_reset_pf_en", pf_en, 1'b1);
    rst = 1'b1;
    req0_valid = 1'b0;
    #1;
    chk_quiet("mid_reset");
    @(negedge iclk);
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge iclk);
    #1;
    chk1("post_rst_grant0", req0_ready, 1'b1);
    chk1("post_rst_grant1", req1_ready, 1'b0);
    stream(1'b0, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    chk("final_inflight", 32'(inflight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
